// File: rtl/linear_network_unicast_arbiter_pkg.sv
// Shared defaults, FSM encoding and index helper for the unicast network arbiter.
package linear_network_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int NUM_NODE_DEF      = 4;
  localparam int COMMAND_WIDTH_DEF = $clog2(NUM_NODE_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linear_network_unicast_arbiter_rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot gnt, zero if none.
// Purely combinational, no backpressure of its own.
module rr_arbiter
  import linear_network_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/linear_network_unicast_arbiter.sv
// Round-robin burst arbiter feeding one beat per cycle into a linear network.
// Latency 1 (registered net outputs); i_stall freezes everything, ready only while granted.
module linear_network_unicast_arbiter
  import linear_network_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int NUM_NODE      = NUM_NODE_DEF,
  parameter int COMMAND_WIDTH = $clog2(NUM_NODE),
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*COMMAND_WIDTH-1:0] i_req_dest,
  input  logic                             i_stall,
  output logic                             o_net_valid,
  output logic [DATA_WIDTH-1:0]            o_net_data,
  output logic [COMMAND_WIDTH-1:0]         o_net_cmd,
  output logic                             o_net_en,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic                             o_err
);

  localparam int PTR_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [COMMAND_WIDTH-1:0] cmd;
    logic [DATA_WIDTH-1:0]    dat;
  } beat_t;

  arb_state_t         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt, arb_idx;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt, arb_gnt;
  beat_t              req_beat [NUM_REQ];
  beat_t              cur_beat, net_beat;
  logic               accept, dest_legal, net_valid, err;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_beat[r] = {i_req_dest[r*COMMAND_WIDTH +: COMMAND_WIDTH],
                          i_req_data[r*DATA_WIDTH +: DATA_WIDTH]};
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req (i_req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign cur_beat    = req_beat[owner];
  assign accept      = (state == ST_GRANT) && !i_stall && i_req_valid[owner];
  assign dest_legal  = 32'(cur_beat.cmd) < 32'(NUM_NODE);
  assign o_req_ready = ((state == ST_GRANT) && !i_stall) ? grant : '0;

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    count_nxt  = count;
    grant_nxt  = grant;
    if (!i_stall) begin
      unique case (state)
        ST_IDLE: begin
          if (|i_req_valid) begin
            state_nxt = ST_GRANT;
            grant_nxt = arb_gnt;
            owner_nxt = arb_idx;
            count_nxt = '0;
          end
        end
        ST_GRANT: begin
          if (accept) count_nxt = count + 1'b1;
          // Burst-full and owner-drop in the same cycle collapse into one release.
          if (!i_req_valid[owner] || (count_nxt == CNT_W'(MAX_BURST))) begin
            state_nxt  = ST_IDLE;
            grant_nxt  = '0;
            count_nxt  = '0;
            rr_ptr_nxt = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      count  <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      count  <= count_nxt;
      grant  <= grant_nxt;
    end
  end

  // Illegal destinations are swallowed: consumed from the requester, flagged, never forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_valid <= 1'b0;
      net_beat  <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !dest_legal;
      if (!i_stall) begin
        net_valid <= accept && dest_legal;
        if (accept && dest_legal) net_beat <= cur_beat;
      end
    end
  end

  assign o_net_valid = net_valid;
  assign o_net_data  = net_beat.dat;
  assign o_net_cmd   = net_beat.cmd;
  assign o_net_en    = ~i_stall;
  assign o_grant     = grant;
  assign o_err       = err;

endmodule

// File: doc/linear_network_unicast_arbiter.md
LINEAR_NETWORK_UNICAST_ARBITER -- requirements
Module: linear_network_unicast_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the data width of each beat.
REQ-002 Parameter NUM_NODE, default 4, sets the number of network destination nodes.
REQ-003 Parameter COMMAND_WIDTH, default $clog2(NUM_NODE), sets the destination tag width.
REQ-004 Parameter NUM_REQ, default 4, sets the number of requesters.
REQ-005 Parameter MAX_BURST, default 4, sets the maximum beats per grant (minimum 1).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_req_valid  in  NUM_REQ  per-requester beat valid.
REQ-009 o_req_ready  out  NUM_REQ  per-requester beat accept.
REQ-010 i_req_data  in  NUM_REQ*DATA_WIDTH  requester r payload at [r*DATA_WIDTH+:DATA_WIDTH].
REQ-011 i_req_dest  in  NUM_REQ*COMMAND_WIDTH  requester r destination tag at [r*COMMAND_WIDTH+:COMMAND_WIDTH].
REQ-012 i_stall  in  1  downstream hold; freezes the network and this block.
REQ-013 o_net_valid  out  1  drives the network i_valid.
REQ-014 o_net_data  out  DATA_WIDTH  drives the network i_data_bus.
REQ-015 o_net_cmd  out  COMMAND_WIDTH  drives the network i_cmd.
REQ-016 o_net_en  out  1  drives the network i_en; equals ~i_stall combinationally.
REQ-017 o_grant  out  NUM_REQ  one-hot current owner; all zero when idle.
REQ-018 o_err  out  1  one-cycle pulse marking a dropped beat with an illegal destination.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-020 In IDLE with any i_req_valid set and i_stall low, the block SHALL select the first valid requester at or after rr_ptr (wrapping) and enter GRANT next cycle with o_grant one-hot on it.
REQ-021 In IDLE, o_req_ready SHALL be all zero.
REQ-022 In GRANT, o_req_ready[g] SHALL equal ~i_stall; all other ready bits SHALL be zero.
REQ-023 A beat is accepted when i_req_valid[g] and o_req_ready[g] are both high.
REQ-024 An accepted beat SHALL appear on o_net_data/o_net_cmd with o_net_valid=1 exactly one cycle later (latency 1, registered outputs).
REQ-025 With i_stall low and no accept, o_net_valid SHALL be 0 next cycle.
REQ-026 With i_stall high, o_net_valid, o_net_data, o_net_cmd, the burst counter, the FSM state and rr_ptr SHALL all hold.
REQ-027 The burst counter SHALL reset to 0 on entry to GRANT and increment on each accept.
REQ-028 GRANT SHALL return to IDLE after the accept that brings the count to MAX_BURST.
REQ-029 GRANT SHALL also return to IDLE when i_req_valid[g] is low and i_stall is low.
REQ-030 On every release, rr_ptr SHALL become (g+1) mod NUM_REQ, and o_grant SHALL clear.
REQ-031 Exactly one idle bubble cycle SHALL separate consecutive grants.
REQ-032 An accepted beat whose dest is >= NUM_NODE SHALL be consumed but not forwarded: o_net_valid=0 and o_err=1 in the following cycle.
REQ-033 A requester dropping valid in the same cycle the count reaches MAX_BURST SHALL produce a single release, not two.

Reset
REQ-034 While rst is high: state=IDLE, rr_ptr=0, count=0, o_net_valid=0, o_net_data=0, o_net_cmd=0, o_grant=0, o_err=0, o_req_ready=0.
REQ-035 Reset asserted mid-burst SHALL discard the in-flight beat with no partial output.
REQ-036 Arbitration SHALL restart from requester 0 on the first edge after reset release.

Structure
REQ-037 Package linear_network_pkg SHALL hold DATA_WIDTH, NUM_NODE, COMMAND_WIDTH defaults and the FSM state encoding.
REQ-038 Round-robin selection SHALL be a separate sub-module rr_arbiter with inputs req[NUM_REQ] and ptr, and one-hot output gnt[NUM_REQ].
REQ-039 The target implementation size is 150-300 lines of RTL.

Verification
REQ-040 Requester 2 alone, valid held for 6 beats (data 0xAAAAAAAA, dest 1) -> 4 beats on the network at cycles t+2..t+5, one bubble, regrant to 2, remaining 2 beats delivered.
REQ-041 All four requesters valid continuously after reset -> grant order 0,1,2,3,0, each grant lasting 4 beats, one bubble between grants.
REQ-042 i_stall high for 3 cycles mid-burst -> o_net_en=0, outputs frozen, no accepts; the burst resumes with the count preserved.
REQ-043 NUM_NODE=3 with dest=3 accepted -> o_err pulses once, o_net_valid=0, the next legal beat is forwarded normally.
REQ-044 rst asserted during beat 2 of a burst -> all outputs zero within the same cycle (async); after release the first grant goes to requester 0.
REQ-045 Requester 1 drops valid after 2 beats -> release, rr_ptr=2, requester 2 is granted next even if requester 1 reasserts.
